// File: rtl/seven_seg_pkg.sv
// Shared seven-segment table used by the display driver and the capture monitor.
// Patterns are {g,f,e,d,c,b,a}, active high.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;
  localparam seg_t SEG_A = 7'h77;
  localparam seg_t SEG_B = 7'h7C;
  localparam seg_t SEG_C = 7'h39;
  localparam seg_t SEG_D = 7'h5E;
  localparam seg_t SEG_E = 7'h79;
  localparam seg_t SEG_F = 7'h71;

  // Returns {err,nibble}; unknown patterns map to 0 with err set.
  function automatic logic [4:0] seg_to_nibble(input seg_t s);
    logic [4:0] r;
    case (s)
      SEG_0:   r = 5'h00;
      SEG_1:   r = 5'h01;
      SEG_2:   r = 5'h02;
      SEG_3:   r = 5'h03;
      SEG_4:   r = 5'h04;
      SEG_5:   r = 5'h05;
      SEG_6:   r = 5'h06;
      SEG_7:   r = 5'h07;
      SEG_8:   r = 5'h08;
      SEG_9:   r = 5'h09;
      SEG_A:   r = 5'h0A;
      SEG_B:   r = 5'h0B;
      SEG_C:   r = 5'h0C;
      SEG_D:   r = 5'h0D;
      SEG_E:   r = 5'h0E;
      SEG_F:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seven_segment_capture_if.sv
// Output word handshake of the seven-segment capture monitor.
// master = producer of num_out, slave = consumer.
interface seven_segment_capture_if #(
  parameter int NUM_DIGITS = 2
) ();

  logic [4*NUM_DIGITS-1:0] num_out;
  logic                    num_valid;
  logic                    num_ready;
  logic                    pattern_err;
  logic                    overrun;

  modport master (
    output num_out,
    output num_valid,
    output pattern_err,
    output overrun,
    input  num_ready
  );

  modport slave (
    input  num_out,
    input  num_valid,
    input  pattern_err,
    input  overrun,
    output num_ready
  );

endinterface

// File: rtl/seven_seg_stable_detect.sv
// Input register, dwell counter and one-shot capture strobe
// for the multiplexed segment bus.
module seven_seg_stable_detect
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  seg_t                  seg_in,
  input  logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  cap_stb,
  output seg_t                  cap_seg,
  output logic [NUM_DIGITS-1:0] cap_sel
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

  seg_t                  seg_d, seg_q, seg_h_q;
  logic [NUM_DIGITS-1:0] sel_d, sel_q, sel_h_q;
  logic [CW-1:0]         cnt_d, cnt_q;
  logic                  one_hot;
  logic                  changed;

  always_comb begin
    seg_d   = SEG_ACTIVE_LOW ? ~seg_in : seg_in;
    sel_d   = SEG_ACTIVE_LOW ? ~dig_sel : dig_sel;
    one_hot = $onehot(sel_q);
    changed = {sel_q, seg_q} != {sel_h_q, seg_h_q};
    cnt_d   = cnt_q;
    if (changed || !one_hot) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Counter saturates past CNT_CAP, so this fires once per dwell.
    cap_stb = !changed && one_hot && (cnt_q == CNT_CAP);
    cap_seg = seg_q;
    cap_sel = sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= '0;
      sel_q   <= '0;
      seg_h_q <= '0;
      sel_h_q <= '0;
      cnt_q   <= '0;
    end else begin
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      seg_h_q <= seg_q;
      sel_h_q <= sel_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Seven-segment bus monitor: assembles captured digits into frames
// and hands completed words out through a valid/ready register.
module seven_segment_capture
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  seg_t                    seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  seven_segment_capture_if.master num_if
);

  localparam int W = 4 * NUM_DIGITS;

  logic                  cap_stb;
  seg_t                  cap_seg;
  logic [NUM_DIGITS-1:0] cap_sel;

  seven_seg_stable_detect #(
    .NUM_DIGITS     (NUM_DIGITS),
    .STABLE_CYCLES  (STABLE_CYCLES),
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_detect (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg_in  (seg_in),
    .dig_sel (dig_sel),
    .cap_stb (cap_stb),
    .cap_seg (cap_seg),
    .cap_sel (cap_sel)
  );

  logic [NUM_DIGITS-1:0][4:0] slots_d, slots_q;
  logic [NUM_DIGITS-1:0]      mask_d, mask_q;
  logic [4:0]                 dec;
  logic [W-1:0]               word;
  logic                       word_err;
  logic                       frame_done;
  logic                       load;

  out_state_e                 state_q;
  logic [W-1:0]               num_out_q;
  logic                       err_q;
  logic                       ovr_q;

  always_comb begin
    dec        = seg_to_nibble(cap_seg);
    frame_done = &mask_q;
    slots_d    = slots_q;
    mask_d     = frame_done ? '0 : mask_q;
    if (cap_stb) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_sel[i]) slots_d[i] = dec;
      end
      mask_d = mask_d | cap_sel;
    end
    word     = '0;
    word_err = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      word[4*i +: 4] = slots_q[i][3:0];
      word_err       = word_err | slots_q[i][4];
    end
    load = frame_done &&
           ((state_q == ST_EMPTY) || num_if.num_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q <= '0;
      mask_q  <= '0;
    end else begin
      slots_q <= slots_d;
      mask_q  <= mask_d;
    end
  end

  // Output register: a frame that cannot be loaded is dropped with a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      num_out_q <= '0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      ovr_q <= frame_done && !load;
      case (state_q)
        ST_EMPTY: begin
          if (load) begin
            state_q   <= ST_FULL;
            num_out_q <= word;
            err_q     <= word_err;
          end
        end
        ST_FULL: begin
          if (load) begin
            num_out_q <= word;
            err_q     <= word_err;
          end else if (num_if.num_ready) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign num_if.num_out     = num_out_q;
  assign num_if.num_valid   = (state_q == ST_FULL);
  assign num_if.pattern_err = err_q;
  assign num_if.overrun     = ovr_q;

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Reader side of the seven-segment display interface: samples a multiplexed segment bus (seg pattern plus one-hot digit select) and recovers the displayed hex number.
- Used as a display-loopback monitor and in self-check benches for the LED driver path.
- Produces one packed number per completed scan frame through a valid/ready handshake, with pattern-error and overrun flags.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits; num_out is 4*NUM_DIGITS bits wide (default gives 8 bits).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted; legal range ≥1.
- SEG_ACTIVE_LOW, 0, when 1, seg_in and dig_sel are inverted at the input register.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_in  input  7  segment pattern {g,f,e,d,c,b,a}; seg_in[0]=a.
- dig_sel  input  NUM_DIGITS  one-hot digit enable; bit i selects nibble i (bit 0 = least-significant nibble).
- num_out  output  4*NUM_DIGITS  recovered number, valid while num_valid=1.
- num_valid  output  1  word available.
- num_ready  input  1  consumer accepts the word when num_valid & num_ready at a rising edge.
- pattern_err  output  1  qualified by num_valid; 1 if any digit of the word held a non-table pattern.
- overrun  output  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset: all registers clear asynchronously. num_out=0, num_valid=0, pattern_err=0, overrun=0, capture mask=0, stability counter=0.
- Input stage: seg_in and dig_sel are registered every cycle, with optional inversion. All further logic uses the registered copy plus a one-deep history.
- Stability counter:
  - Cleared when the registered {dig_sel,seg} differs from the previous value, or when dig_sel is not one-hot (zero or multi-hot).
  - Otherwise increments, saturating at STABLE_CYCLES.
- Capture:
  - Occurs on the cycle the counter reaches STABLE_CYCLES-1 with dig_sel one-hot. It fires exactly once per dwell; no re-capture until the value changes.
  - The decoded nibble and error bit are written to digit slot i, and mask bit i is set.
  - Latency: a value presented unchanged from edge 0 is written at edge STABLE_CYCLES+1.
- Decode table (pattern→nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F. Any other pattern decodes to nibble 0 with the error bit set.
- Re-capture of an already-set digit in the same frame overwrites the slot; the mask is unchanged.
- Frame complete: when the mask becomes all-ones, the next edge does the following:
  - If the output register is empty, or is being consumed in that same cycle, it loads num_out, loads pattern_err as the OR of the slot error bits, and sets num_valid.
  - Otherwise the frame is dropped and overrun pulses for 1 cycle. The current output is kept unchanged.
  - In both cases the mask clears and collection restarts; slot data is retained but overwritten by the next captures.
- Output FSM, 2 states:
  - EMPTY: num_valid=0.
  - FULL: num_valid=1, num_out and pattern_err stable.
  - EMPTY→FULL on frame load. FULL→EMPTY on handshake with no simultaneous load. FULL→FULL on handshake with a simultaneous load, which presents the new word.
  - num_valid never drops without a handshake.
- Collection continues regardless of output state; there is no backpressure to the display bus.
- Reset asserted mid-frame discards partial captures. After release, a full new frame is required before num_valid.

Decomposition:
- A shared package seven_seg_pkg holds:
  - the segment-pattern constants SEG_0..SEG_F;
  - the typedef seg_t (logic [6:0]);
  - the function seg_to_nibble returning {err,nibble}.
  The LED driver's encoding is defined from this same package so both ends share one table.
- One sub-module, seven_seg_stable_detect, contains the input register, stability counter and one-shot capture strobe. Frame assembly and the output FSM stay in the top.

Test Plan:
1. Basic frame (defaults). Drive dig_sel=01/seg=4F for 6 cycles, then dig_sel=10/seg=66 for 6 cycles, with num_ready=1. Expect num_out=8'h43, pattern_err=0, num_valid high for 1 cycle.
2. Glitch rejection. Hold digit 0 at 06, then insert a 3-cycle 7F pulse (shorter than STABLE_CYCLES) before returning to 06 for 6 cycles. Hold digit 1 at 5B. Expect a single word 8'h21, with the 7F pulse never captured.
3. Invalid pattern. Digit 0 = 00, digit 1 = 71. Expect num_out=8'hF0, pattern_err=1.
4. Backpressure/overrun. Hold num_ready=0 and complete frame 12 then frame 34. Expect num_valid held with 8'h12 throughout and one overrun pulse at frame 2 completion. Raise num_ready and expect 8'h12 accepted, then num_valid=0.
5. Non-one-hot select. Apply dig_sel=11 with seg=3F for 10 cycles. Expect no capture, mask=0, num_valid stays 0.
6. Reset mid-frame. Capture digit 0 = 7, pulse rst_n low for 1 cycle, then capture digit 1 = 9 only. Expect num_valid=0. A subsequent full frame of 5,9 produces exactly one word, 8'h95.
